// File: rtl/dpram_stream_reader.sv
// Streams a contiguous dpram address range (1-cycle registered read) as valid/ready beats
// through a 2-entry skid buffer. Define DPRAM_RD_DOUBLE_EN to compile in pixel doubling.
module dpram_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_abort,
  input  logic                  i_dbl,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [LEN_WIDTH-1:0]  r_issue_left;
  logic [LEN_WIDTH-1:0]  r_pop_left;
  logic                  r_inflight;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [1:0]            r_cnt;

  logic       w_busy;
  logic       w_idle_start;
  logic       w_accept;
  logic       w_abort;
  logic       w_hs;
  logic       w_pop;
  logic       w_push;
  logic       w_issue;
  logic       w_last_issue;
  logic       w_last_pop;
  logic [1:0] w_occ;
  logic [2:0] w_commit;

  assign w_busy       = (r_state != IDLE);
  assign w_idle_start = (r_state == IDLE) && i_start;
  assign w_accept     = w_idle_start && (i_len != '0);
  assign w_abort      = i_abort && w_busy;
  assign w_hs         = o_out_valid && i_out_ready;

`ifdef DPRAM_RD_DOUBLE_EN
  logic r_dbl;
  logic r_phase;

  // r_phase marks that the head entry has already been emitted once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dbl   <= 1'b0;
      r_phase <= 1'b0;
    end else if (w_accept) begin
      r_dbl   <= i_dbl;
      r_phase <= 1'b0;
    end else if (w_abort) begin
      r_phase <= 1'b0;
    end else if (w_hs && r_dbl) begin
      r_phase <= ~r_phase;
    end
  end

  assign w_pop = w_hs && (!r_dbl || r_phase);
`else
  logic w_unused_dbl;
  assign w_unused_dbl = i_dbl;
  assign w_pop        = w_hs;
`endif

  // Issue only if the buffer can still absorb everything already committed plus this read
  assign w_occ        = r_cnt - {1'b0, w_pop};
  assign w_commit     = {1'b0, w_occ} + {2'b00, r_inflight};
  assign w_issue      = (r_state == FETCH) && !w_abort && (w_commit < 3'd2);
  assign w_push       = r_inflight && !w_abort;
  assign w_last_issue = w_issue && (r_issue_left == LEN_WIDTH'(1));
  assign w_last_pop   = w_pop && !w_abort && (r_pop_left == LEN_WIDTH'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = FETCH;
      FETCH:   if (w_last_issue) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_pop) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_abort) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rd_addr    <= '0;
      r_issue_left <= '0;
      r_pop_left   <= '0;
      r_inflight   <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      r_done     <= w_last_pop || (w_idle_start && (i_len == '0));
      if (w_accept) begin
        r_rd_addr    <= i_base_addr;
        r_issue_left <= i_len;
        r_pop_left   <= i_len;
      end else begin
        if (w_issue) begin
          r_rd_addr    <= r_rd_addr + ADDR_WIDTH'(1);
          r_issue_left <= r_issue_left - LEN_WIDTH'(1);
        end
        if (w_pop) r_pop_left <= r_pop_left - LEN_WIDTH'(1);
      end
    end
  end

  // Skid buffer: r_buf0 is the head and drives the stream directly
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_buf0 <= '0;
    end else if (w_abort) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_buf0 <= i_rd_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11:   r_buf0 <= (r_cnt == 2'd2) ? r_buf1 : i_rd_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && (((r_cnt == 2'd1) && !w_pop) || ((r_cnt == 2'd2) && w_pop)))
      r_buf1 <= i_rd_data;
  end

  assign o_rd_addr   = r_rd_addr;
  assign o_out_data  = r_buf0;
  assign o_out_valid = (r_cnt != 2'd0);
  assign o_busy      = w_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench for dpram_stream_reader against a behavioural registered-read dpram (mem[i]=i).
module tb_dpram_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       dbl = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] base_addr = 8'h00;
  logic [8:0] len = 9'd0;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];
  logic [7:0] rx [$];
  logic [7:0] exp_q [$];
  int         rx_base = 0;
  int         n_done = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  dpram_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LEN_WIDTH(9)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_len       (len),
    .i_abort     (abort),
    .i_dbl       (dbl),
    .o_rd_addr   (rd_addr),
    .i_rd_data   (rd_data),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one cycle; logs handshakes/done of the current cycle and checks stall stability
  task automatic cyc();
    logic       stall;
    logic [7:0] d;
    if (rst_n && out_valid && out_ready) rx.push_back(out_data);
    if (rst_n && done) n_done++;
    stall = rst_n && out_valid && !out_ready && !abort;
    d     = out_data;
    @(posedge clk);
    #1;
    if (stall && rst_n) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(d));
    end
  endtask

  task automatic kick(input logic [7:0] b, input logic [8:0] l, input logic d);
    base_addr = b;
    len       = l;
    dbl       = d;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int k = 0;
    while (!done && k < lim) begin
      cyc();
      k++;
    end
    chk(tag, 32'(done), 32'd1);
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_count"}, 32'(rx.size() - rx_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (rx_base + i) < rx.size(); i++)
      chk(tag, 32'(rx[rx_base + i]), 32'(exp_q[i]));
  endtask

  task automatic fill_exp(input logic [7:0] b, input int n, input int rep);
    exp_q.delete();
    for (int i = 0; i < n; i++)
      for (int r = 0; r < rep; r++) exp_q.push_back(8'(b + 8'(i)));
  endtask

  logic [31:0] rp = 32'b1011_0110_0110_1101_0011_0100_1010_0000;
  int nd0;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_rd_addr", 32'(rd_addr), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // Basic cycle-exact run: base 0x10, len 4, always ready
    kick(8'h10, 9'd4, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      if (c <= 4) chk("t1_rd_addr", 32'(rd_addr), 32'h10 + 32'(c) - 32'd1);
      chk("t1_valid", 32'(out_valid), (c >= 3 && c <= 6) ? 32'd1 : 32'd0);
      if (c >= 3 && c <= 6) chk("t1_data", 32'(out_data), 32'h10 + 32'(c) - 32'd3);
      chk("t1_busy", 32'(busy), (c <= 6) ? 32'd1 : 32'd0);
      chk("t1_done", 32'(done), (c == 7) ? 32'd1 : 32'd0);
      cyc();
    end

    // Address wrap
    rx_base = rx.size();
    kick(8'hFE, 9'd4, 1'b0);
    wait_done("t2_done", 40);
    fill_exp(8'hFE, 4, 1);
    check_rx("t2_wrap");

    // Backpressure: full stall first, then an irregular ready pattern
    rx_base = rx.size();
    kick(8'h30, 9'd4, 1'b0);
    for (int k = 0; k < 80 && !done; k++) begin
      out_ready = rp[k % 32];
      if (k == 4) begin
        chk("t3_rd_addr_held", 32'(rd_addr), 32'h32);
        chk("t3_full_valid", 32'(out_valid), 32'd1);
        chk("t3_full_data", 32'(out_data), 32'h30);
      end
      cyc();
    end
    chk("t3_done", 32'(done), 32'd1);
    out_ready = 1'b1;
    fill_exp(8'h30, 4, 1);
    check_rx("t3_stall");

    // Zero-length start, then a start while busy
    cyc();
    kick(8'h55, 9'd0, 1'b0);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_rd_addr", 32'(rd_addr), 32'h34);
    chk("t4_valid", 32'(out_valid), 32'd0);
    cyc();
    chk("t4_done_pulse", 32'(done), 32'd0);
    rx_base = rx.size();
    kick(8'h60, 9'd3, 1'b0);
    base_addr = 8'h90;
    len       = 9'd7;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
    wait_done("t4b_done", 40);
    fill_exp(8'h60, 3, 1);
    check_rx("t4b_ignore");
    cyc();

    // Abort in cycle 5, restart in cycle 6
    kick(8'h80, 9'd8, 1'b0);
    cyc(); cyc(); cyc(); cyc();
    nd0   = n_done;
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    rx_base = rx.size();
    kick(8'h40, 9'd2, 1'b0);
    chk("t5_no_done", 32'(done), 32'd0);
    wait_done("t5b_done", 30);
    cyc();
    chk("t5_done_count", 32'(n_done - nd0), 32'd1);
    fill_exp(8'h40, 2, 1);
    check_rx("t5_restart");

    // Reset mid-transfer discards everything
    kick(8'hA0, 9'd8, 1'b0);
    cyc(); cyc(); cyc();
    rst_n = 1'b0;
    cyc();
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_rd_addr", 32'(rd_addr), 32'h0);
    chk("t6_rst_data", 32'(out_data), 32'h0);
    rst_n = 1'b1;
    nd0   = n_done;
    for (int i = 0; i < 10; i++) cyc();
    chk("t6_no_done", 32'(n_done - nd0), 32'd0);
    chk("t6_idle_valid", 32'(out_valid), 32'd0);

    // Pixel doubling request
    rx_base = rx.size();
    kick(8'h20, 9'd3, 1'b1);
    wait_done("t7_done", 40);
    dbl = 1'b0;
`ifdef DPRAM_RD_DOUBLE_EN
    fill_exp(8'h20, 3, 2);
`else
    fill_exp(8'h20, 3, 1);
`endif
    check_rx("t7_dbl");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
